// File: rtl/dma_pkg.sv
// dma_pkg: definitions shared by the DMA copy sequencer and its staging FIFO.
//   - dma_state_e  : sequencer states
//   - BEAT_*       : Beat output codes (INCR, INCR4, INCR8, INCR16)
//   - HSIZE_WORD   : transfer size driven on Size
//   - HTRANS/HBURST/HRESP constants used by the DMA-to-AHB bridge
//   - burst_cmd_t / make_cmd : shape of the next burst for a given word count
package dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_DATA,
      S_WR_REQ,
      S_WR_DATA,
      S_DONE,
      S_ERR
   } dma_state_e;

   localparam logic [2:0] BEAT_INCR    = 3'b000;
   localparam logic [2:0] BEAT_INCR4   = 3'b001;
   localparam logic [2:0] BEAT_INCR8   = 3'b010;
   localparam logic [2:0] BEAT_INCR16  = 3'b011;

   localparam logic [2:0] HSIZE_WORD   = 3'b010;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;
   localparam logic [1:0] HRESP_RETRY   = 2'b10;
   localparam logic [1:0] HRESP_SPLIT   = 2'b11;

   typedef struct packed {
      logic [31:0] addr;
      logic [4:0]  beats;
      logic        burst;
      logic [2:0]  beat;
   } burst_cmd_t;

   function automatic logic [2:0] full_beat_code(input int unsigned beats);
      case (beats)
         4:       return BEAT_INCR4;
         8:       return BEAT_INCR8;
         16:      return BEAT_INCR16;
         default: return BEAT_INCR;
      endcase
   endfunction

   // Next burst: n = min(remaining, max_beats); fixed-length code only
   // when the burst is full, undefined-length INCR for short bursts,
   // single transfer when n == 1.
   function automatic burst_cmd_t make_cmd(input logic [31:0] addr,
                                           input logic [15:0] remaining,
                                           input int unsigned max_beats);
      burst_cmd_t c;
      c.addr  = addr;
      c.beats = (32'(remaining) >= max_beats) ? 5'(max_beats) : remaining[4:0];
      c.burst = (c.beats > 5'd1);
      c.beat  = (32'(c.beats) == max_beats) ? full_beat_code(max_beats) : BEAT_INCR;
      return c;
   endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: single-clock staging FIFO between read and write bursts.
//   HCLK, HRST_N : clock, asynchronous active-low reset
//   flush        : empties the FIFO (takes priority over push/pop)
//   push, din    : write one word (ignored when full)
//   pop          : drop the head word (ignored when empty)
//   dout         : head word (show-ahead)
//   full, empty, count : occupancy status
module dma_sync_fifo
   import dma_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       HCLK,
   input  logic                       HRST_N,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (32'(p) == DEPTH - 1) return '0;
      else                     return p + 1'b1;
   endfunction

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge HCLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge HCLK or negedge HRST_N) begin
      if (!HRST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl: single-channel memory-to-memory copy sequencer on the DMA
// AHB master port. Copies LenWords words from SrcAddr to DstAddr as
// alternating read/write bursts of up to BURST_BEATS words via a local FIFO.
//   CPU side   : Start, Abort, SrcAddr, DstAddr, LenWords -> Busy_o, Done,
//                Err, ErrAddr
//   Master port: Request, Lock, Burst, Busy, Write, Beat, Size, Addr,
//                DataIn (write data = FIFO head) out;
//                DataOut, DataReady, Grant, Okay, Error, Retry in
module dma_copy_ctrl
   import dma_pkg::*;
#(
   parameter int unsigned BURST_BEATS = 8,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic        HCLK,
   input  logic        HRST_N,
   input  logic        Start,
   input  logic        Abort,
   input  logic [31:0] SrcAddr,
   input  logic [31:0] DstAddr,
   input  logic [15:0] LenWords,
   output logic        Busy_o,
   output logic        Done,
   output logic        Err,
   output logic [31:0] ErrAddr,
   output logic        Request,
   output logic        Lock,
   output logic        Burst,
   output logic        Busy,
   output logic        Write,
   output logic [2:0]  Beat,
   output logic [2:0]  Size,
   output logic [31:0] Addr,
   output logic [31:0] DataIn,
   input  logic [31:0] DataOut,
   input  logic        DataReady,
   input  logic        Grant,
   input  logic        Okay,
   input  logic        Error,
   input  logic        Retry
);

   dma_state_e  state;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] remaining;
   logic [4:0]  chunk;
   logic [4:0]  grant_cnt;
   logic [4:0]  okay_cnt;

   logic [31:0] src_next;
   logic [31:0] dst_next;
   logic [15:0] rem_next;
   logic [31:0] beat_addr;
   logic        last_okay;
   logic        launch;
   logic        launch_wr;
   burst_cmd_t  next_cmd;

   logic        in_rd;
   logic        in_wr;
   logic        in_xfer;
   logic        rd_beat;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_flush;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;
   logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_unused;

   assign Lock = 1'b0;
   assign Busy = 1'b0;
   assign Size = HSIZE_WORD;

   assign in_rd   = (state == S_RD_REQ) || (state == S_RD_DATA);
   assign in_wr   = (state == S_WR_REQ) || (state == S_WR_DATA);
   assign in_xfer = in_rd || in_wr;

   // Error wins over a same-cycle Okay/DataReady: nothing moves through
   // the FIFO on that cycle, it is flushed instead.
   assign rd_beat    = in_rd && DataReady && !Error;
   assign fifo_push  = rd_beat && !fifo_full;
   assign fifo_pop   = in_wr && Okay && !Error;
   assign fifo_flush = in_xfer && Error;
   assign DataIn     = fifo_empty ? '0 : fifo_head;

   assign beat_addr  = Addr + {25'd0, okay_cnt, 2'b00};

   always_comb begin
      src_next  = src_addr + {25'd0, chunk, 2'b00};
      dst_next  = dst_addr + {25'd0, chunk, 2'b00};
      rem_next  = remaining - 16'(chunk);
      last_okay = Okay && !Error && ((okay_cnt + 5'd1) == chunk);
      launch_wr = (state == S_RD_DATA);
      case (state)
         S_IDLE:    next_cmd = make_cmd({SrcAddr[31:2], 2'b00}, LenWords, BURST_BEATS);
         S_RD_DATA: next_cmd = make_cmd(dst_addr, remaining, BURST_BEATS);
         default:   next_cmd = make_cmd(src_next, rem_next, BURST_BEATS);
      endcase
      launch = ((state == S_IDLE) && Start && (LenWords != '0))
            || ((state == S_RD_DATA) && last_okay)
            || ((state == S_WR_DATA) && last_okay && (rem_next != '0) && !Abort);
   end

   // Burst set-up (Request/Addr/Write/Burst/Beat/counters) is shared by the
   // three places a burst starts and is applied after the state case.
   always_ff @(posedge HCLK or negedge HRST_N) begin
      if (!HRST_N) begin
         state     <= S_IDLE;
         src_addr  <= '0;
         dst_addr  <= '0;
         remaining <= '0;
         chunk     <= '0;
         grant_cnt <= '0;
         okay_cnt  <= '0;
         Busy_o    <= 1'b0;
         Done      <= 1'b0;
         Err       <= 1'b0;
         ErrAddr   <= '0;
         Request   <= 1'b0;
         Burst     <= 1'b0;
         Write     <= 1'b0;
         Beat      <= BEAT_INCR;
         Addr      <= '0;
      end else begin
         Done <= 1'b0;
         Err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  src_addr  <= {SrcAddr[31:2], 2'b00};
                  dst_addr  <= {DstAddr[31:2], 2'b00};
                  remaining <= LenWords;
                  if (LenWords == '0) begin
                     state <= S_DONE;
                     Done  <= 1'b1;
                  end else begin
                     state  <= S_RD_REQ;
                     Busy_o <= 1'b1;
                  end
               end
            end
            S_RD_REQ, S_WR_REQ: begin
               if (Error) begin
                  ErrAddr <= beat_addr;
                  Err     <= 1'b1;
                  Busy_o  <= 1'b0;
                  Request <= 1'b0;
                  state   <= S_ERR;
               end else begin
                  if (Okay) okay_cnt <= okay_cnt + 5'd1;
                  if (Grant) begin
                     grant_cnt <= grant_cnt + 5'd1;
                     if ((grant_cnt + 5'd1) == chunk) begin
                        Request <= 1'b0;
                        state   <= (state == S_RD_REQ) ? S_RD_DATA : S_WR_DATA;
                     end
                  end
               end
            end
            S_RD_DATA, S_WR_DATA: begin
               if (Error) begin
                  ErrAddr <= beat_addr;
                  Err     <= 1'b1;
                  Busy_o  <= 1'b0;
                  Request <= 1'b0;
                  state   <= S_ERR;
               end else begin
                  // A retried beat is replayed by the port; keep asking
                  // until every beat of the burst has been acknowledged.
                  if (Retry) Request <= 1'b1;
                  if (Okay)  okay_cnt <= okay_cnt + 5'd1;
                  if (last_okay) begin
                     if (state == S_RD_DATA) begin
                        state <= S_WR_REQ;
                     end else begin
                        src_addr  <= src_next;
                        dst_addr  <= dst_next;
                        remaining <= rem_next;
                        if ((rem_next == '0) || Abort) begin
                           state   <= S_DONE;
                           Done    <= 1'b1;
                           Busy_o  <= 1'b0;
                           Request <= 1'b0;
                        end else begin
                           state <= S_RD_REQ;
                        end
                     end
                  end
               end
            end
            S_DONE, S_ERR: state <= S_IDLE;
            default:       state <= S_IDLE;
         endcase

         if (launch) begin
            Request   <= 1'b1;
            Write     <= launch_wr;
            Addr      <= next_cmd.addr;
            chunk     <= next_cmd.beats;
            Burst     <= next_cmd.burst;
            Beat      <= next_cmd.beat;
            grant_cnt <= '0;
            okay_cnt  <= '0;
         end
      end
   end

   dma_sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .HCLK   (HCLK),
      .HRST_N (HRST_N),
      .flush  (fifo_flush),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .din    (DataOut),
      .dout   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count_unused)
   );

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// tb_dma_copy_ctrl: drives dma_copy_ctrl as the master-port slave and CPU,
// predicting burst shapes, addresses, data and pulses from the copy rules.
module tb_dma_copy_ctrl;
   import dma_pkg::*;

   localparam int unsigned BB = 8;

   logic        HCLK = 1'b0;
   logic        HRST_N = 1'b0;
   logic        Start = 1'b0;
   logic        Abort = 1'b0;
   logic [31:0] SrcAddr = '0;
   logic [31:0] DstAddr = '0;
   logic [15:0] LenWords = '0;
   logic        Busy_o, Done, Err, Request, Lock, Burst, Busy, Write;
   logic [31:0] ErrAddr, Addr, DataIn;
   logic [2:0]  Beat, Size;
   logic [31:0] DataOut = '0;
   logic        DataReady = 1'b0, Grant = 1'b0, Okay = 1'b0, Error = 1'b0, Retry = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [31:0] src_mem [logic [31:0]];
   logic [109:0] outvec;
   localparam logic [109:0] RESET_VEC = {5'b0, 3'b000, 3'b010, 99'b0};

   assign outvec = {Request, Lock, Burst, Busy, Write, Beat, Size, Addr,
                    Busy_o, Done, Err, ErrAddr, DataIn};

   dma_copy_ctrl #(
      .BURST_BEATS (BB),
      .FIFO_DEPTH  (16)
   ) dut (
      .HCLK      (HCLK),
      .HRST_N    (HRST_N),
      .Start     (Start),
      .Abort     (Abort),
      .SrcAddr   (SrcAddr),
      .DstAddr   (DstAddr),
      .LenWords  (LenWords),
      .Busy_o    (Busy_o),
      .Done      (Done),
      .Err       (Err),
      .ErrAddr   (ErrAddr),
      .Request   (Request),
      .Lock      (Lock),
      .Burst     (Burst),
      .Busy      (Busy),
      .Write     (Write),
      .Beat      (Beat),
      .Size      (Size),
      .Addr      (Addr),
      .DataIn    (DataIn),
      .DataOut   (DataOut),
      .DataReady (DataReady),
      .Grant     (Grant),
      .Okay      (Okay),
      .Error     (Error),
      .Retry     (Retry)
   );

   always #5 HCLK = ~HCLK;

   // The FIFO must never be offered a word while it is full.
   always @(negedge HCLK) begin
      if (HRST_N && dut.rd_beat && dut.fifo_full) begin
         errors++;
         $display("FAIL fifo_overflow: push while full at %0t", $time);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (!src_mem.exists(a)) src_mem[a] = $urandom;
      return src_mem[a];
   endfunction

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   // Plays one burst as the slave. status: 0 ok, 1 errored, 2 halted, 3 timeout.
   task automatic serve_burst(input bit wr, input logic [31:0] addr, input logic [31:0] dat,
                              input int n, input int retry_idx, input int err_idx,
                              input int halt_idx, output int status);
      int waited;
      bit retried;
      logic [2:0] exp_beat;
      logic [31:0] exp_word;
      status = 0;
      waited = 0;
      retried = 0;
      exp_beat = (n == BB) ? 3'b010 : 3'b000;
      while (Request !== 1'b1 && waited < 16) begin
         step();
         waited++;
      end
      checks++;
      if (Request !== 1'b1) begin
         errors++;
         $display("FAIL req_timeout: Request=%b required 1 (burst at %h)", Request, addr);
         status = 3;
         return;
      end
      checks++;
      if (Addr !== addr || Write !== wr || Burst !== (n > 1) || Beat !== exp_beat) begin
         errors++;
         $display("FAIL burst_ctrl: Addr=%h Write=%b Burst=%b Beat=%b required %h %b %b %b",
                  Addr, Write, Burst, Beat, addr, wr, (n > 1), exp_beat);
      end
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) step();
         Grant = 1'b1;
         step();
         Grant = 1'b0;
      end
      checks++;
      if (Request !== 1'b0) begin
         errors++;
         $display("FAIL req_drop: Request=%b required 0 after last grant at %h", Request, addr);
      end
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) step();
         if (i == halt_idx) begin
            status = 2;
            return;
         end
         if (i == retry_idx && !retried) begin
            retried = 1;
            Retry = 1'b1;
            step();
            Retry = 1'b0;
            checks++;
            if (Request !== 1'b1) begin
               errors++;
               $display("FAIL retry_hold: Request=%b required 1 after Retry", Request);
            end
         end
         if (wr) begin
            exp_word = word_at(dat + 32'(4 * i));
            checks++;
            if (DataIn !== exp_word) begin
               errors++;
               $display("FAIL wdata: DataIn=%h required %h (dst %h)", DataIn, exp_word,
                        addr + 32'(4 * i));
            end
         end
         if (i == err_idx) begin
            Error = 1'b1;
            Okay = 1'b1;
            step();
            Error = 1'b0;
            Okay = 1'b0;
            status = 1;
            return;
         end
         Okay = 1'b1;
         if (!wr) begin
            DataReady = 1'b1;
            DataOut = word_at(addr + 32'(4 * i));
         end
         step();
         Okay = 1'b0;
         DataReady = 1'b0;
         DataOut = $urandom;
      end
   endtask

   // Runs one whole copy job against the reference split into bursts.
   task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                          input int retry_at, input int err_at, input bit abort_first,
                          input bit poke_start, output int status, output int words);
      logic [31:0] s, d;
      int rem, n, base, st, ri, ei;
      s = {src[31:2], 2'b00};
      d = {dst[31:2], 2'b00};
      status = 0;
      words = 0;
      SrcAddr = src;
      DstAddr = dst;
      LenWords = len;
      Start = 1'b1;
      step();
      Start = 1'b0;
      SrcAddr = $urandom;
      DstAddr = $urandom;
      LenWords = 16'($urandom);
      if (len == 16'd0) begin
         checks++;
         if (Done !== 1'b1 || Request !== 1'b0 || Busy_o !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: Done=%b Request=%b Busy_o=%b required 1 0 0",
                     Done, Request, Busy_o);
         end
         step();
         checks++;
         if (Done !== 1'b0 || Request !== 1'b0) begin
            errors++;
            $display("FAIL len0_after: Done=%b Request=%b required 0 0", Done, Request);
         end
         return;
      end
      checks++;
      if (Request !== 1'b1 || Busy_o !== 1'b1) begin
         errors++;
         $display("FAIL start_req: Request=%b Busy_o=%b required 1 1", Request, Busy_o);
      end
      rem = int'(len);
      base = 0;
      while (rem > 0) begin
         n = (rem < int'(BB)) ? rem : int'(BB);
         if (abort_first) Abort = 1'b1;
         if (poke_start && base == 0) begin
            Start = 1'b1;
            step();
            Start = 1'b0;
         end
         ri = (retry_at >= base && retry_at < base + n) ? retry_at - base : -1;
         ei = (err_at >= base && err_at < base + n) ? err_at - base : -1;
         serve_burst(1'b0, s, s, n, ri, -1, -1, st);
         if (st != 0) begin
            status = st;
            return;
         end
         serve_burst(1'b1, d, s, n, -1, ei, -1, st);
         if (st != 0) begin
            status = st;
            return;
         end
         rem -= n;
         s += 32'(4 * n);
         d += 32'(4 * n);
         base += n;
         words = base;
         if (abort_first) break;
      end
      checks++;
      if (Done !== 1'b1 || Busy_o !== 1'b0 || Request !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: Done=%b Busy_o=%b Request=%b required 1 0 0",
                  Done, Busy_o, Request);
      end
      step();
      checks++;
      if (Done !== 1'b0 || dut.state !== S_IDLE) begin
         errors++;
         $display("FAIL done_end: Done=%b state=%0d required 0 IDLE", Done, dut.state);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (outvec !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_outputs: %h required %h", outvec, RESET_VEC);
      end
      @(negedge HCLK);
      HRST_N = 1'b1;
      step();
      checks++;
      if (outvec !== RESET_VEC || dut.state !== S_IDLE || dut.fifo_empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: %h state=%0d required %h IDLE", outvec, dut.state, RESET_VEC);
      end
   endtask

   task automatic test_single_burst();
      int st, w;
      do_copy(32'h0000_1000, 32'h0000_2000, 16'd8, -1, -1, 1'b0, 1'b0, st, w);
      checks++;
      if (st != 0 || w != 8) begin
         errors++;
         $display("FAIL single_burst: status=%0d words=%0d required 0 8", st, w);
      end
   endtask

   task automatic test_multi_burst();
      int st, w;
      do_copy(32'h0000_1000, 32'h0000_2000, 16'd19, -1, -1, 1'b0, 1'b0, st, w);
      checks++;
      if (st != 0 || w != 19) begin
         errors++;
         $display("FAIL multi_burst: status=%0d words=%0d required 0 19", st, w);
      end
   endtask

   task automatic test_short_lengths();
      int st, w;
      do_copy(32'h0000_5004, 32'h0000_6008, 16'd1, -1, -1, 1'b0, 1'b0, st, w);
      checks++;
      if (st != 0 || w != 1) begin
         errors++;
         $display("FAIL len1: status=%0d words=%0d required 0 1", st, w);
      end
      do_copy(32'h0000_5000, 32'h0000_6000, 16'd0, -1, -1, 1'b0, 1'b0, st, w);
   endtask

   task automatic test_retry();
      int st, w;
      do_copy(32'h0000_1000, 32'h0000_2000, 16'd8, 2, -1, 1'b0, 1'b0, st, w);
      checks++;
      if (st != 0 || w != 8) begin
         errors++;
         $display("FAIL retry_job: status=%0d words=%0d required 0 8", st, w);
      end
   endtask

   task automatic test_error();
      int st, w;
      do_copy(32'h0000_1000, 32'h0000_2000, 16'd8, -1, 4, 1'b0, 1'b0, st, w);
      checks++;
      if (st != 1) begin
         errors++;
         $display("FAIL err_status: status=%0d required 1", st);
      end
      checks++;
      if (Err !== 1'b1 || ErrAddr !== 32'h0000_2010 || Request !== 1'b0 || Busy_o !== 1'b0
          || dut.fifo_empty !== 1'b1) begin
         errors++;
         $display("FAIL err_pulse: Err=%b ErrAddr=%h Request=%b Busy_o=%b empty=%b required 1 00002010 0 0 1",
                  Err, ErrAddr, Request, Busy_o, dut.fifo_empty);
      end
      step();
      checks++;
      if (Err !== 1'b0 || dut.state !== S_IDLE || ErrAddr !== 32'h0000_2010) begin
         errors++;
         $display("FAIL err_end: Err=%b state=%0d ErrAddr=%h required 0 IDLE 00002010",
                  Err, dut.state, ErrAddr);
      end
   endtask

   task automatic test_abort();
      int st, w;
      do_copy(32'h0000_3000, 32'h0000_4000, 16'd32, -1, -1, 1'b1, 1'b0, st, w);
      Abort = 1'b0;
      checks++;
      if (st != 0 || w != 8) begin
         errors++;
         $display("FAIL abort_words: status=%0d words=%0d required 0 8", st, w);
      end
      checks++;
      if (dut.remaining !== 16'd24) begin
         errors++;
         $display("FAIL abort_remaining: remaining=%0d required 24", dut.remaining);
      end
   endtask

   task automatic test_start_ignored();
      int st, w;
      do_copy(32'h0000_7000, 32'h0000_8000, 16'd12, -1, -1, 1'b0, 1'b1, st, w);
      checks++;
      if (st != 0 || w != 12) begin
         errors++;
         $display("FAIL start_ignored: status=%0d words=%0d required 0 12", st, w);
      end
   endtask

   task automatic test_random();
      int st, w, len, ra;
      for (int j = 0; j < 6; j++) begin
         len = $urandom_range(1, 40);
         ra = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
         do_copy($urandom, $urandom, 16'(len), ra, -1, 1'b0, 1'b0, st, w);
         checks++;
         if (st != 0 || w != len) begin
            errors++;
            $display("FAIL random_job%0d: status=%0d words=%0d required 0 %0d", j, st, w, len);
         end
      end
   endtask

   task automatic test_reset_midwrite();
      int st;
      SrcAddr = 32'h0000_9000;
      DstAddr = 32'h0000_A000;
      LenWords = 16'd16;
      Start = 1'b1;
      step();
      Start = 1'b0;
      serve_burst(1'b0, 32'h0000_9000, 32'h0000_9000, 8, -1, -1, -1, st);
      serve_burst(1'b1, 32'h0000_A000, 32'h0000_9000, 8, -1, -1, 3, st);
      checks++;
      if (st != 2 || Busy_o !== 1'b1) begin
         errors++;
         $display("FAIL midwrite_setup: status=%0d Busy_o=%b required 2 1", st, Busy_o);
      end
      #2;
      HRST_N = 1'b0;
      #1;
      checks++;
      if (outvec !== RESET_VEC || dut.state !== S_IDLE || dut.fifo_empty !== 1'b1) begin
         errors++;
         $display("FAIL midwrite_reset: %h state=%0d required %h IDLE", outvec, dut.state, RESET_VEC);
      end
      @(negedge HCLK);
      HRST_N = 1'b1;
      step();
      checks++;
      if (Request !== 1'b0 || Busy_o !== 1'b0 || dut.state !== S_IDLE) begin
         errors++;
         $display("FAIL midwrite_release: Request=%b Busy_o=%b state=%0d required 0 0 IDLE",
                  Request, Busy_o, dut.state);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_multi_burst();
      test_short_lengths();
      test_retry();
      test_error();
      test_abort();
      test_start_ignored();
      test_random();
      test_reset_midwrite();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
